// File: rtl/fifo_byte_reader.sv
// Purpose: pulls words from a FIFO and streams them MSB byte first as framed bytes (sof/eof, frame counter).
// Latency: first byte appears 3 cycles after fifo_empty drops; outputs are registered; reads are >= 3 cycles apart.
// Backpressure: byte_ready low holds byte_data/sof/eof; FIFO underflow parks in IDLE and resumes mid-frame.
// Option: define FIFO_READER_HEADER_EN to prefix each frame with 0xA5, frame_count[7:0].
module fifo_byte_reader #(
  parameter int DATA_WIDTH      = 48,
  parameter int WORDS_PER_FRAME = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_data_out_valid,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enabled,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  byte_sof,
  output logic                  byte_eof,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef FIFO_READER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SHIFT
`ifdef FIFO_READER_HEADER_EN
    , HDR
`endif
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [7:0]            word_idx;
  logic [BW-1:0]         byte_idx;
  logic                  last_word;
`ifdef FIFO_READER_HEADER_EN
  // frame_open stops the header from repeating if the FIFO underflows before word 0 arrives
  logic                  frame_open;
  logic                  hdr_idx;
`endif

  assign shift_next = shift_reg << 8;
  assign last_word  = (word_idx == 8'(WORDS_PER_FRAME - 1));
  assign busy       = (state != IDLE);

  // Reader FSM: every output is registered and updated on the transition that produces it
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      fifo_read_enabled <= 1'b0;
      byte_valid        <= 1'b0;
      byte_sof          <= 1'b0;
      byte_eof          <= 1'b0;
      byte_data         <= 8'h00;
      frame_count       <= 16'h0000;
      word_idx          <= 8'd0;
      byte_idx          <= '0;
      shift_reg         <= '0;
`ifdef FIFO_READER_HEADER_EN
      frame_open        <= 1'b0;
      hdr_idx           <= 1'b0;
`endif
    end else begin
      fifo_read_enabled <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
`ifdef FIFO_READER_HEADER_EN
            if (!frame_open) begin
              state      <= HDR;
              frame_open <= 1'b1;
              hdr_idx    <= 1'b0;
              byte_valid <= 1'b1;
              byte_data  <= 8'hA5;
              byte_sof   <= 1'b1;
              byte_eof   <= 1'b0;
            end else begin
              state             <= REQ;
              fifo_read_enabled <= 1'b1;
            end
`else
            state             <= REQ;
            fifo_read_enabled <= 1'b1;
`endif
          end
        end

        REQ: begin
          state <= WAIT;
        end

        // A read issued on a stale non-empty flag returns no data; index is kept so the frame resumes
        WAIT: begin
          if (fifo_data_out_valid) begin
            state      <= SHIFT;
            shift_reg  <= fifo_data_out;
            byte_valid <= 1'b1;
            byte_data  <= fifo_data_out[DATA_WIDTH-1 -: 8];
            byte_sof   <= !HDR_EN && (word_idx == 8'd0);
            byte_eof   <= (BYTES == 1) && last_word;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          if (byte_ready) begin
            shift_reg <= shift_next;
            byte_sof  <= 1'b0;
            if (byte_idx == BW'(BYTES - 1)) begin
              byte_valid <= 1'b0;
              byte_eof   <= 1'b0;
              byte_idx   <= '0;
              if (last_word) begin
                word_idx    <= 8'd0;
                frame_count <= frame_count + 16'd1;
                state       <= IDLE;
`ifdef FIFO_READER_HEADER_EN
                frame_open  <= 1'b0;
`endif
              end else begin
                word_idx <= word_idx + 8'd1;
                // Skip the request when the FIFO already reports empty; IDLE picks up on refill
                if (!fifo_empty) begin
                  state             <= REQ;
                  fifo_read_enabled <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              byte_idx  <= byte_idx + BW'(1);
              byte_data <= shift_next[DATA_WIDTH-1 -: 8];
              byte_eof  <= last_word && (int'(byte_idx) == BYTES - 2);
            end
          end
        end

`ifdef FIFO_READER_HEADER_EN
        HDR: begin
          if (byte_ready) begin
            if (!hdr_idx) begin
              hdr_idx   <= 1'b1;
              byte_data <= frame_count[7:0];
              byte_sof  <= 1'b0;
            end else begin
              hdr_idx    <= 1'b0;
              byte_valid <= 1'b0;
              if (!fifo_empty) begin
                state             <= REQ;
                fifo_read_enabled <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_reader.sv
`timescale 1ns/1ps
module tb_fifo_byte_reader;

  localparam int DW  = 48;
  localparam int WPF = 16;
  localparam int BPW = DW / 8;
`ifdef FIFO_READER_HEADER_EN
  localparam int HDR_BYTES = 2;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int FRAME_BYTES = HDR_BYTES + WPF * BPW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_data_out_valid = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_enabled;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic          byte_sof;
  logic          byte_eof;
  logic [15:0]   frame_count;
  logic          busy;

  always #5 clk = ~clk;

  fifo_byte_reader #(.DATA_WIDTH(DW), .WORDS_PER_FRAME(WPF)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fifo_data_out       (fifo_data_out),
    .fifo_data_out_valid (fifo_data_out_valid),
    .fifo_empty          (fifo_empty),
    .fifo_read_enabled   (fifo_read_enabled),
    .byte_data           (byte_data),
    .byte_valid          (byte_valid),
    .byte_ready          (byte_ready),
    .byte_sof            (byte_sof),
    .byte_eof            (byte_eof),
    .frame_count         (frame_count),
    .busy                (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: one-cycle read latency, empty flag lags occupancy by one cycle
  logic [DW-1:0] fifo_q[$];
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_data_out_valid <= 1'b0;
      fifo_empty          <= 1'b1;
    end else begin
      fifo_empty <= (fifo_q.size() == 0);
      if (fifo_read_enabled === 1'b1 && fifo_q.size() != 0) begin
        fifo_data_out       <= fifo_q.pop_front();
        fifo_data_out_valid <= 1'b1;
      end else begin
        fifo_data_out_valid <= 1'b0;
      end
    end
  end

  // Reference model: expected byte stream built from each pushed word
  typedef struct packed { logic [7:0] data; logic sof; logic eof; } exp_t;
  exp_t exp_q[$];
  int   m_word   = 0;
  int   m_frames = 0;

  task automatic push_word(input logic [DW-1:0] w);
    exp_t e;
    if (m_word == 0 && HDR_BYTES > 0) begin
      e.data = 8'hA5; e.sof = 1'b1; e.eof = 1'b0; exp_q.push_back(e);
      e.data = 8'(m_frames); e.sof = 1'b0; exp_q.push_back(e);
    end
    for (int i = 0; i < BPW; i++) begin
      e.data = w[DW-1-8*i -: 8];
      e.sof  = (HDR_BYTES == 0) && (m_word == 0) && (i == 0);
      e.eof  = (m_word == WPF - 1) && (i == BPW - 1);
      exp_q.push_back(e);
    end
    m_word++;
    if (m_word == WPF) begin
      m_word = 0;
      m_frames++;
    end
    fifo_q.push_back(w);
  endtask

  // byte_ready driver: 0 = always ready, 1 = toggling, 2 = random
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       byte_ready = 1'b1;
      1:       byte_ready = ~byte_ready;
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: scoreboard, hold-stability and read-spacing checks, sampled mid-cycle
  int         acc = 0;
  int         sof_pos = 0;
  int         eof_pos = 0;
  int         cyc = 0;
  int         last_read = -100;
  logic [7:0] got_q[$];
  logic       hold = 1'b0;
  logic [9:0] hold_v;
  exp_t       mon_e;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold)
        check("hold_stable", {byte_valid, byte_data, byte_sof, byte_eof}, {1'b1, hold_v});
      if (fifo_read_enabled) begin
        check("read_while_empty", fifo_empty, 1'b0);
        check("read_spacing", (cyc - last_read) >= 3, 1'b1);
        last_read = cyc;
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("stream_byte", {byte_data, byte_sof, byte_eof}, mon_e);
        end
        got_q.push_back(byte_data);
        acc++;
        if (byte_sof) sof_pos = acc;
        if (byte_eof) eof_pos = acc;
      end
      hold   = byte_valid && !byte_ready;
      hold_v = {byte_data, byte_sof, byte_eof};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int n = 0;
    while (acc < target && n < budget) begin
      step();
      n++;
    end
    check(name, acc >= target, 1'b1);
  endtask

  typedef struct {
    logic [DW-1:0]     word;
    int                mode;
    logic [0:5][7:0]   exp;
  } vec_t;

  initial begin
    vec_t       vecs[4];
    logic [7:0] first6[6];
    int         base;
    int         pre;

    vecs[0].word = 48'h112233445566; vecs[0].mode = 1; vecs[0].exp = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    vecs[1].word = 48'hA1B2C3D4E5F6; vecs[1].mode = 2; vecs[1].exp = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    vecs[2].word = 48'hFF0000FF8001; vecs[2].mode = 0; vecs[2].exp = {8'hFF, 8'h00, 8'h00, 8'hFF, 8'h80, 8'h01};
    vecs[3].word = 48'h0123456789AB; vecs[3].mode = 1; vecs[3].exp = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    first6 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

    // Reset state
    repeat (3) step();
    check("rst_valid", byte_valid, 1'b0);
    check("rst_rd_en", fifo_read_enabled, 1'b0);
    check("rst_sof", byte_sof, 1'b0);
    check("rst_eof", byte_eof, 1'b0);
    check("rst_data", byte_data, 8'h00);
    check("rst_frame_count", frame_count, 16'h0000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Preloaded frame of words 1..16 with byte_ready held high
    ready_mode = 0;
    base = acc;
    got_q.delete();
    for (int w = 1; w <= WPF; w++) push_word(DW'(w));
    wait_acc(base + FRAME_BYTES, 2000, "frame1_timeout");
    step(); step();
    for (int i = 0; i < 6; i++) check("frame1_first_bytes", got_q[HDR_BYTES + i], first6[i]);
    check("frame1_len", got_q.size(), FRAME_BYTES);
    check("frame1_sof_pos", sof_pos, base + 1);
    check("frame1_eof_pos", eof_pos, base + FRAME_BYTES);
    check("frame1_count", frame_count, 16'd1);
    check("frame1_idle", busy, 1'b0);

    // Table: single words under different byte_ready patterns
    for (int v = 0; v < 4; v++) begin
      ready_mode = vecs[v].mode;
      pre = (m_word == 0) ? HDR_BYTES : 0;
      got_q.delete();
      base = acc;
      push_word(vecs[v].word);
      wait_acc(base + pre + BPW, 300, "vec_timeout");
      for (int i = 0; i < BPW; i++) check("vec_byte", got_q[pre + i], vecs[v].exp[i]);
    end

    // Underflow after word 5, refill 20 cycles later
    ready_mode = 2;
    base = acc;
    for (int w = 4; w <= 5; w++) push_word({$urandom, 16'($urandom)});
    wait_acc(base + 2 * BPW, 300, "underflow_pre_timeout");
    base = acc;
    repeat (20) step();
    check("underflow_no_bytes", acc, base);
    check("underflow_no_valid", byte_valid, 1'b0);
    check("underflow_count", frame_count, 16'd1);
    for (int w = 6; w < WPF; w++) push_word({$urandom, 16'($urandom)});
    wait_acc(base + (WPF - 6) * BPW, 2000, "underflow_post_timeout");
    step(); step();
    check("underflow_eof_last", eof_pos, acc);
    check("underflow_count2", frame_count, 16'd2);
    check("underflow_drained", exp_q.size(), 0);

    // Reset pulse during byte 2 of word 7
    ready_mode = 0;
    base = acc;
    for (int w = 0; w < WPF; w++) push_word({$urandom, 16'($urandom)});
    wait_acc(base + HDR_BYTES + 7 * BPW + 2, 1000, "midrst_timeout");
    check("midrst_presenting", byte_valid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    m_word = 0;
    m_frames = 0;
    step();
    rst = 1'b0;
    check("midrst_valid", byte_valid, 1'b0);
    check("midrst_count", frame_count, 16'd0);
    step(); step();
    ready_mode = 2;
    base = acc;
    for (int w = 0; w < WPF; w++) push_word({$urandom, 16'($urandom)});
    wait_acc(base + FRAME_BYTES, 3000, "postrst_timeout");
    step(); step();
    check("postrst_sof_pos", sof_pos, base + 1);
    check("postrst_count", frame_count, 16'd1);

    // Random frames with random refill gaps and random byte_ready
    base = acc;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < WPF; w++) begin
        push_word({$urandom, 16'($urandom)});
        repeat ($urandom_range(0, 12)) step();
      end
    end
    wait_acc(base + 3 * FRAME_BYTES, 6000, "random_timeout");
    step(); step();
    check("random_count", frame_count, 16'(m_frames));
    check("random_drained", exp_q.size(), 0);
    check("random_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_byte_reader.md
FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 48, meaning FIFO word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter WORDS_PER_FRAME, default 16, meaning FIFO words per output frame; SHALL be 1..255.
REQ-003 clk  input  1  single clock; all logic SHALL run on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fifo_data_out  input  DATA_WIDTH  read data from the FIFO.
REQ-006 fifo_data_out_valid  input  1  FIFO read-data-valid flag, one cycle after a read request.
REQ-007 fifo_empty  input  1  FIFO empty flag (registered; may lag occupancy by one cycle).
REQ-008 fifo_read_enabled  output  1  single-cycle read request to the FIFO.
REQ-009 byte_data  output  8  output byte stream, MSB byte of each word first.
REQ-010 byte_valid  output  1  byte_data holds a valid byte.
REQ-011 byte_ready  input  1  downstream (W5500 SPI writer) accepts the byte.
REQ-012 byte_sof  output  1  current byte is the first byte of a frame.
REQ-013 byte_eof  output  1  current byte is the last byte of a frame.
REQ-014 frame_count  output  16  number of completed frames, wraps 0xFFFF -> 0x0000.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, SHIFT; plus HDR when FIFO_READER_HEADER_EN is defined.
REQ-017 IDLE -> REQ when fifo_empty=0 (or -> HDR first when a frame is starting and the header is compiled in).
REQ-018 REQ SHALL assert fifo_read_enabled for exactly one cycle, then go to WAIT; fifo_read_enabled SHALL be 0 in all other states.
REQ-019 WAIT: if fifo_data_out_valid=1, latch fifo_data_out into the shift register and go to SHIFT; else return to IDLE with word index unchanged.
REQ-020 Reads SHALL be spaced at least 3 cycles apart, so the lagging fifo_empty flag can never cause a read from an empty FIFO to be counted as data.
REQ-021 SHIFT: byte_valid=1, byte_data = top byte of the shift register; on byte_valid&&byte_ready, shift left by 8 bits and advance the byte index.
REQ-022 byte_data, byte_sof and byte_eof SHALL be held stable while byte_valid=1 and byte_ready=0.
REQ-023 After byte DATA_WIDTH/8-1 of a word is accepted: if word index < WORDS_PER_FRAME-1, increment it and go to REQ; else clear it, increment frame_count and go to IDLE.
REQ-024 byte_eof SHALL be 1 only on the last byte of word WORDS_PER_FRAME-1.
REQ-025 byte_sof SHALL be 1 only on the first byte of a frame: the first header byte, or byte 0 of word 0 without the header.
REQ-026 FIFO underflow mid-frame SHALL stall in IDLE; the frame resumes at the next word index without re-asserting byte_sof.
REQ-027 byte_ready asserted while byte_valid=0 SHALL be ignored.

Reset
REQ-028 While rst=1 at a clk edge, these SHALL be forced and then held: state=IDLE; fifo_read_enabled=0; byte_valid=0; byte_sof=0; byte_eof=0; byte_data=0x00; frame_count=0; word index=0; byte index=0; shift register=0.
REQ-029 Reset mid-frame SHALL abandon the partial frame; the next frame SHALL start with byte_sof=1.

Configuration
REQ-030 Macro FIFO_READER_HEADER_EN: when defined, each frame SHALL be prefixed in HDR with 2 bytes, 0xA5 then frame_count[7:0]; these bytes use the same handshake as data bytes, and byte_sof is on 0xA5.
REQ-031 Without FIFO_READER_HEADER_EN: no HDR state, and frames SHALL consist of data bytes only (WORDS_PER_FRAME*DATA_WIDTH/8 bytes).

Verification
REQ-032 Defaults, no header, FIFO preloaded with 16 words 0x000000000001..0x000000000010, byte_ready=1 -> 96 bytes; first six bytes are 00 00 00 00 00 01; sof on byte 1, eof on byte 96; frame_count=1.
REQ-033 Word 0x112233445566, byte_ready toggling 1/0 each cycle -> bytes 11,22,33,44,55,66 in order, each held stable while byte_ready=0.
REQ-034 FIFO empties after word 5 of a frame, refilled 20 cycles later -> fifo_read_enabled is never asserted while fifo_empty=1; frame continues at word 6 with no second sof; eof on the 96th byte.
REQ-035 FIFO_READER_HEADER_EN defined, frame_count=3 -> frame starts A5 03 with sof on A5; total 98 bytes.
REQ-036 rst pulsed for 1 cycle during byte 2 of word 7 -> next cycle: byte_valid=0, frame_count=0; next emitted byte carries sof=1.
